// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line, read handshake and status flags of the UART receiver.
// The receiver sits on the slave side; the host/consumer drives rx and dataRead.
interface uart_receiver_if;
    logic       rx;
    logic       dataRead;
    logic [7:0] rxData;
    logic       dataRdy;
    logic       rxCtlFlow;
    logic       framingErr;
    logic       overrun;

    modport master (
        output rx, dataRead,
        input  rxData, dataRdy, rxCtlFlow, framingErr, overrun
    );

    modport slave (
        input  rx, dataRead,
        output rxData, dataRdy, rxCtlFlow, framingErr, overrun
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver with mid-bit sampling, start/stop validation,
// a single-byte ready/read holding register and a flow-control output.
module uart_receiver #(
    parameter int clks_per_bit = 108,
    parameter int half_bit     = clks_per_bit / 2
) (
    input  logic clk,
    input  logic rst,
    uart_receiver_if.slave bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
    localparam logic [7:0] LAST = 8'(clks_per_bit - 1);
    localparam logic [7:0] HALF = 8'(half_bit - 1);

    logic       s1, s2;
    logic [2:0] state;
    logic [7:0] clkCnt;
    logic [2:0] bitIdx;
    logic [7:0] shiftReg;
    logic [7:0] rxData;
    logic       dataRdy, rxCtlFlow, framingErr, overrun;
    logic       stopOk, accept, rdyNext;

    // A good stop bit is taken if the holding register is free or being read in the same cycle.
    assign stopOk  = state == STOP && clkCnt == LAST && s2;
    assign accept  = stopOk && (!dataRdy || bus.dataRead);
    assign rdyNext = accept ? 1'b1 : (bus.dataRead ? 1'b0 : dataRdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            state      <= IDLE;
            clkCnt     <= '0;
            bitIdx     <= '0;
            shiftReg   <= '0;
            rxData     <= '0;
            dataRdy    <= 1'b0;
            rxCtlFlow  <= 1'b0;
            framingErr <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            s1         <= bus.rx;
            s2         <= s1;
            framingErr <= 1'b0;
            clkCnt     <= clkCnt + 8'd1;
            case (state)
                IDLE: begin
                    clkCnt <= '0;
                    if (!s2) state <= START;
                end
                START: if (clkCnt == HALF) begin
                    clkCnt <= '0;
                    bitIdx <= '0;
                    state  <= s2 ? IDLE : DATA;
                end
                DATA: if (clkCnt == LAST) begin
                    clkCnt   <= '0;
                    shiftReg <= {s2, shiftReg[7:1]};
                    bitIdx   <= bitIdx + 3'd1;
                    if (bitIdx == 3'd7) state <= STOP;
                end
                STOP: if (clkCnt == LAST) begin
                    clkCnt     <= '0;
                    framingErr <= !s2;
                    state      <= s2 ? IDLE : WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    clkCnt <= '0;
                    if (s2) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            rxData    <= accept ? shiftReg : rxData;
            dataRdy   <= rdyNext;
            rxCtlFlow <= rdyNext;
            if (stopOk && !accept) overrun <= 1'b1;
            else if (bus.dataRead && !stopOk) overrun <= 1'b0;
        end
    end

    assign bus.rxData     = rxData;
    assign bus.dataRdy    = dataRdy;
    assign bus.rxCtlFlow  = rxCtlFlow;
    assign bus.framingErr = framingErr;
    assign bus.overrun    = overrun;
endmodule
